router_fifo: RTL



---
 rtl/router_fifo.sv | 80 ++++++++
 1 files changed

// File: rtl/router_fifo.sv
// Output-side packet FIFO; entries carry a header flag so the read side tracks packet length.
// Latency: read data registered, valid one cycle after the accepting edge; no write-to-read bypass.
// Backpressure: full drops writes silently, empty ignores reads; data_out clears once a packet drains.
module router_fifo #(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 16,  // must equal 2**ADDR_W
    parameter int ADDR_W = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             soft_reset,
    input  logic             write_enb,
    input  logic             read_enb,
    input  logic             lfd_state,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    output logic             full,
    output logic             empty
);

    localparam logic [ADDR_W:0]  PTR_ONE = 1;
    localparam logic [WIDTH-2:0] CNT_ONE = 1;

    // Bit WIDTH of each entry is the header flag.
    logic [WIDTH:0]   mem [DEPTH];
    logic [ADDR_W:0]  wr_ptr;
    logic [ADDR_W:0]  rd_ptr;
    logic [WIDTH-2:0] pkt_count;
    logic [WIDTH:0]   rd_entry;
    logic             wr_acc;
    logic             rd_acc;

    // Flags come straight from the registered pointers; the extra MSB separates full from empty.
    assign full     = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                      (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
    assign empty    = (wr_ptr == rd_ptr);
    assign wr_acc   = write_enb && !full;
    assign rd_acc   = read_enb && !empty;
    assign rd_entry = mem[rd_ptr[ADDR_W-1:0]];

    // Storage array and write pointer; a write while full leaves both untouched.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (soft_reset) begin
            wr_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (wr_acc) begin
            mem[wr_ptr[ADDR_W-1:0]] <= {lfd_state, data_in};
            wr_ptr                  <= wr_ptr + PTR_ONE;
        end
    end

    // Read pointer, registered read data and packet length tracking with drain-to-zero.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_ptr    <= '0;
            pkt_count <= '0;
            data_out  <= '0;
        end else if (soft_reset) begin
            rd_ptr    <= '0;
            pkt_count <= '0;
            data_out  <= '0;
        end else if (rd_acc) begin
            data_out <= rd_entry[WIDTH-1:0];
            rd_ptr   <= rd_ptr + PTR_ONE;
            if (rd_entry[WIDTH]) begin
                // Header: payload length field plus the trailing parity byte. Reloads even
                // if the previous packet was truncated.
                pkt_count <= {1'b0, rd_entry[WIDTH-1:2]} + CNT_ONE;
            end else if (pkt_count != '0) begin
                pkt_count <= pkt_count - CNT_ONE;
            end
        end else if (pkt_count == '0) begin
            data_out <= '0;
        end
    end

endmodule
